frame_scheduler: RTL

Per-frame sequencer for the 3D renderer's double-buffered framebuffer. Each frame it clears the back buffer's depth/colour, pulses start to the world drawer and waits for its done. It then waits for vertical sync and swaps front/back buffers. It sits between the video timing generator, the world drawer and the framebuffer write mux; it owns the clear write port and the buffer-select bit.

---
 rtl/frame_scheduler_if.sv | 34 +++
 rtl/frame_scheduler.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/frame_scheduler_if.sv
// Frame scheduler bus: frame enable, vsync, drawer start/done handshake, clear write port and status.
// master: the scheduler (drives start, clear port, buffer select and status).
// slave: video timing / world drawer / framebuffer write mux side.
interface frame_scheduler_if #(
  parameter int FB_ADDR_BITS    = 16,
  parameter int DEPTH_BIT_WIDTH = 16,
  parameter int FB_BIT_WIDTH    = 100
);
  logic                       frame_en;
  logic                       vsync_in;
  logic                       draw_start;
  logic                       draw_done;
  logic                       clear_we;
  logic [FB_ADDR_BITS-1:0]    clear_addr;
  logic [DEPTH_BIT_WIDTH-1:0] clear_depth;
  logic [FB_BIT_WIDTH-1:0]    clear_color;
  logic                       buffer_sel;
  logic                       busy;
  logic                       overrun;
  logic [15:0]                frame_count;
  logic [31:0]                render_cycles;

  modport master (
    input  frame_en, vsync_in, draw_done,
    output draw_start, clear_we, clear_addr, clear_depth, clear_color,
           buffer_sel, busy, overrun, frame_count, render_cycles
  );

  modport slave (
    output frame_en, vsync_in, draw_done,
    input  draw_start, clear_we, clear_addr, clear_depth, clear_color,
           buffer_sel, busy, overrun, frame_count, render_cycles
  );
endinterface

// File: rtl/frame_scheduler.sv
// Purpose: per-frame sequencer for a double-buffered framebuffer: clear back buffer, run drawer, swap on vsync.
// Latency: clear takes FB_WIDTH*FB_HEIGHT cycles; swap lands the cycle after draw_done/vsync rise, whichever is later.
// Backpressure: none; drawer is a start/done handshake, a vsync edge missed while rendering sets sticky overrun.
// Ports: clk_in, rst_in_n (async active-low, released through a 2-flop synchroniser);
//        bus (frame_scheduler_if.master): frame_en, vsync_in, draw_done in; draw_start, clear_we/addr/depth/color,
//        buffer_sel, busy, overrun, frame_count, render_cycles out.
// Optional: define FRAME_SCHEDULER_PERF_EN to build the draw-time counter behind render_cycles (otherwise 0).
module frame_scheduler #(
  parameter int                      FB_WIDTH        = 320,
  parameter int                      FB_HEIGHT       = 180,
  parameter int                      FB_ADDR_BITS    = 16,
  parameter int                      DEPTH_BIT_WIDTH = 16,
  parameter int                      FB_BIT_WIDTH    = 100,
  parameter logic [FB_BIT_WIDTH-1:0] CLEAR_COLOR     = '0
) (
  input  logic                clk_in,
  input  logic                rst_in_n,
  frame_scheduler_if.master   bus
);

  localparam int unsigned FB_WORDS = FB_WIDTH * FB_HEIGHT;
  localparam logic [FB_ADDR_BITS-1:0] LAST_ADDR = FB_ADDR_BITS'(FB_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAW,
    ST_WAIT_VSYNC,
    ST_SWAP
  } state_t;

  // Reset asserts immediately, releases two clock edges after rst_in_n rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  state_t                  state_q, state_d;
  logic                    vsync_q;
  logic [FB_ADDR_BITS-1:0] clear_addr_q;
  logic                    draw_first_q;
  logic                    buffer_sel_q;
  logic                    overrun_q;
  logic [15:0]             frame_count_q;

  logic vs_rise;
  logic in_clear;
  logic in_draw;
  logic clear_last;
  logic done_ok;

  assign vs_rise    = bus.vsync_in & ~vsync_q;
  assign in_clear   = (state_q == ST_CLEAR);
  assign in_draw    = (state_q == ST_DRAW);
  assign clear_last = (clear_addr_q == LAST_ADDR);
  // draw_done is not honoured on the cycle draw_start is issued.
  assign done_ok    = in_draw & ~draw_first_q & bus.draw_done;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (bus.frame_en) state_d = ST_CLEAR;
      ST_CLEAR:      if (clear_last) state_d = ST_DRAW;
      ST_DRAW:       if (done_ok) state_d = vs_rise ? ST_SWAP : ST_WAIT_VSYNC;
      ST_WAIT_VSYNC: if (vs_rise) state_d = ST_SWAP;
      ST_SWAP:       state_d = bus.frame_en ? ST_CLEAR : ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= 1'b0;
      clear_addr_q  <= '0;
      draw_first_q  <= 1'b0;
      buffer_sel_q  <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      vsync_q <= bus.vsync_in;
      // Address parks at 0 outside CLEAR so every clear pass starts from word 0.
      clear_addr_q <= (in_clear && !clear_last) ? clear_addr_q + FB_ADDR_BITS'(1) : '0;
      draw_first_q <= in_clear && clear_last;
      if (state_q == ST_SWAP) begin
        buffer_sel_q  <= ~buffer_sel_q;
        frame_count_q <= frame_count_q + 16'd1;
      end
      if (vs_rise && (in_clear || (in_draw && !done_ok))) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.draw_start  = in_draw & draw_first_q;
  assign bus.clear_we    = in_clear;
  assign bus.clear_addr  = clear_addr_q;
  assign bus.clear_depth = '1;
  assign bus.clear_color = CLEAR_COLOR;
  assign bus.buffer_sel  = buffer_sel_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.overrun     = overrun_q;
  assign bus.frame_count = frame_count_q;

`ifdef FRAME_SCHEDULER_PERF_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] render_cycles_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q      <= '0;
      render_cycles_q <= '0;
    end else begin
      if (bus.draw_start) begin
        perf_cnt_q <= '0;
      end else if (in_draw) begin
        perf_cnt_q <= sat_inc(perf_cnt_q);
      end
      // Counter lags one cycle behind the draw_start cycle, hence the +1.
      if (done_ok) begin
        render_cycles_q <= sat_inc(perf_cnt_q);
      end
    end
  end

  assign bus.render_cycles = render_cycles_q;
`else
  assign bus.render_cycles = 32'd0;
`endif

endmodule
